mem_hs_param: RTL
=================

// Module: mem_hs_param
// PURPOSE
//   Parametrised successor to the node data memory: byte-addressed, big-endian,
//   WORD_BYTES-wide words, with a valid/ready request port and byte enables.
//   Reads are registered with a fixed 1-cycle latency.
//   An optional post-reset clear sequencer zeroes the whole array.
//   Sits between the routing/Q-learning datapath FSMs and node state storage
//   (flags, sink lists, neighbour tables, HCM).
// PARAMETERS
//   DEPTH           2048  bytes in array; power of two, multiple of WORD_BYTES
//   WORD_BYTES      2     bytes per access word (1..8)
//   CLEAR_ON_RESET  1     1: zero entire array after reset; 0: contents kept
//   ADDR_W          $clog2(DEPTH)  localparam, byte-address width
// PORTS
//   clock      in   1               rising-edge clock
//   reset      in   1               synchronous, active-high reset
//   req_valid  in   1               request present
//   req_ready  out  1               block can accept a request this cycle
//   req_wr     in   1               1 = write, 0 = read
//   req_addr   in   ADDR_W          byte address of most-significant byte
//   req_wdata  in   8*WORD_BYTES    write data, big-endian
//   req_be     in   WORD_BYTES      byte enable; be[i] gates wdata[8i+7:8i]
//   rsp_valid  out  1               read data valid (1-cycle pulse per read)
//   rsp_rdata  out  8*WORD_BYTES    read data, big-endian
//   init_done  out  1               1 once the clear sequence has finished
// BEHAVIOUR
// - Reset (clock edge with reset=1):
//   - req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, clr_cnt=0.
//   - State -> CLEAR if CLEAR_ON_RESET=1, else READY.
// - FSM states CLEAR and READY:
//   - CLEAR: each cycle writes 0 to bytes clr_cnt*WORD_BYTES .. +WORD_BYTES-1,
//     then increments clr_cnt. After clr_cnt = DEPTH/WORD_BYTES-1 is written,
//     go to READY. Clear takes exactly DEPTH/WORD_BYTES cycles.
//     req_ready=0 throughout CLEAR; requests are ignored.
//   - READY: req_ready=1, init_done=1 (both registered; they assert the cycle
//     after leaving CLEAR, or the cycle after reset deasserts when
//     CLEAR_ON_RESET=0). READY is only left via reset.
// - Request accepted on a clock edge with req_valid & req_ready.
// - Byte mapping: byte k (k=0..WORD_BYTES-1) lives at (req_addr+k) mod DEPTH
//   and corresponds to data byte WORD_BYTES-1-k, i.e. the MSB sits at req_addr.
// - Write: byte k is written at the accept edge if be[WORD_BYTES-1-k]=1.
//   - be=0 is a legal no-op.
//   - Writes produce no response; rsp_valid=0 the following cycle.
// - Read: at the accept edge, rsp_rdata <= {mem[a], mem[a+1], ...} mod DEPTH,
//   and rsp_valid <= 1 for exactly the next cycle.
//   - Back-to-back reads give one response per cycle, in order.
//   - rsp_rdata holds its last value while rsp_valid=0.
//   - There is no response backpressure.
// - Write followed by read of the same bytes on the next cycle returns the new
//   data. A request carries only one operation, so there is no same-cycle
//   read/write collision.
// - Unaligned addresses are legal; a word crossing DEPTH-1 wraps to byte 0.
// - Reset mid-operation:
//   - An in-flight read response is dropped (rsp_valid=0 next cycle).
//   - An active CLEAR restarts from clr_cnt=0.
//   - With CLEAR_ON_RESET=0 array contents survive reset.
// - Array has no other initialisation; with CLEAR_ON_RESET=0, pre-reset
//   contents are X in simulation.
// TESTING
// 1. Defaults. Reset 1 cycle -> req_ready=0, init_done=0 for 1024 cycles,
//    then both 1. A read of any address after that -> 16'h0000.
// 2. Write addr 'h688 data 16'h0005 be=2'b11, then read 'h688 next cycle
//    -> rsp_valid exactly 1 cycle later, rsp_rdata=16'h0005.
// 3. Byte enables: write 'h10 = 16'hABCD be=11, then write 'h10 = 16'h1234
//    be=01, then read 'h10 -> 16'hAB34. Read 'h11 (unaligned) -> 16'h3400.
// 4. Wrap: write 'h7FF = 16'hBEEF -> byte 'h7FF=BE, byte 'h000=EF.
//    Read 'h000 -> 16'hEFxx with low byte = old mem['h001].
// 5. Pipelined reads: reads of 'h8, 'hA, 'hC on consecutive cycles, after
//    writing 2, 5, 10 -> rsp_valid high 3 consecutive cycles, data 2, 5, 10.
// 6. Reset mid-op: reset asserted the cycle after a read accept -> no
//    rsp_valid. Reset during CLEAR at clr_cnt=500 -> a further 1024 cycles
//    before init_done. With CLEAR_ON_RESET=0, data written before reset
//    reads back unchanged after reset.

Source files
------------

// File: rtl/mem_hs_param.sv
// mem_hs_param: byte-addressed, big-endian word memory with a valid/ready
// request port, per-byte write enables and a registered 1-cycle read.
// An optional post-reset sequencer zeroes the array one word per cycle.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle (registered)
//   req_wr     1 = write, 0 = read
//   req_addr   byte address of the most-significant byte of the word
//   req_wdata  write data, big-endian
//   req_be     byte enables; req_be[i] gates req_wdata[8i+7:8i]
//   rsp_valid  1-cycle pulse per accepted read
//   rsp_rdata  read data, big-endian; holds while rsp_valid is low
//   init_done  high once the clear sequence has finished
module mem_hs_param #(
    parameter int unsigned DEPTH          = 2048,
    parameter int unsigned WORD_BYTES     = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned ADDR_W        = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [8*WORD_BYTES-1:0] req_wdata,
    input  logic [WORD_BYTES-1:0]   req_be,
    output logic                    rsp_valid,
    output logic [8*WORD_BYTES-1:0] rsp_rdata,
    output logic                    init_done
);

    localparam int unsigned NUM_WORDS = DEPTH / WORD_BYTES;
    localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

    typedef enum logic {StClear, StReady} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic                    clear_en;
    logic                    ready_q;
    logic                    rsp_valid_q;
    logic [8*WORD_BYTES-1:0] rsp_rdata_q;
    logic [8*WORD_BYTES-1:0] rd_word;
    logic [ADDR_W-1:0]       clr_base;
    logic                    accept;

    logic [7:0] mem [DEPTH];

    // Gating with reset keeps a request presented on a reset edge from
    // touching the array or producing a response.
    assign accept   = req_valid & ready_q & ~reset;
    assign clr_base = ADDR_W'(clr_cnt_q * WORD_BYTES);

    // Next-state logic for the clear sequencer.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clear_en  = 1'b0;
        unique case (state_q)
            StClear: begin
                clear_en = 1'b1;
                if (clr_cnt_q == LAST_WORD) begin
                    state_d = StReady;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_W'(1);
                end
            end
            StReady: begin
            end
            default: begin
                state_d = StReady;
            end
        endcase
    end

    // Ready/init_done follow the next state so they rise on the same edge
    // that leaves CLEAR (or the first edge after reset when not clearing).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StReady;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_d == StReady);
        end
    end

    // Array writes: clear sequencer and request port never overlap because
    // ready_q is low throughout CLEAR. The array itself is never reset.
    always_ff @(posedge clock) begin
        if (clear_en && !reset) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                mem[clr_base + ADDR_W'(k)] <= 8'h00;
            end
        end else if (accept && req_wr) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (req_be[WORD_BYTES-1-k]) begin
                    mem[req_addr + ADDR_W'(k)] <= req_wdata[8*(WORD_BYTES-1-k) +: 8];
                end
            end
        end
    end

    // Byte k of the word sits at req_addr+k (wrapping) and is data byte
    // WORD_BYTES-1-k, so the MSB comes from the lowest address.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            rd_word[8*(WORD_BYTES-1-k) +: 8] = mem[req_addr + ADDR_W'(k)];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= accept & ~req_wr;
            if (accept && !req_wr) begin
                rsp_rdata_q <= rd_word;
            end
        end
    end

    assign req_ready = ready_q;
    assign init_done = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
